// File: rtl/icache_if.sv
// icache_if: fetcher and memory-controller handshake bundle for icache
//   slave  (cache side): in_fetcher_*, in_mem_* in; out_fetcher_*, out_mem_* out
//   master (bench/fetcher+memory side): the mirror image
interface icache_if;
   logic        in_fetcher_flag;
   logic [31:0] in_fetcher_pc;
   logic        out_fetcher_flag;
   logic [31:0] out_fetcher_inst;
   logic        out_mem_flag;
   logic [31:0] out_mem_pc;
   logic        in_mem_flag;
   logic [31:0] in_mem_inst;
   modport slave (
      input  in_fetcher_flag, in_fetcher_pc, in_mem_flag, in_mem_inst,
      output out_fetcher_flag, out_fetcher_inst, out_mem_flag, out_mem_pc
   );
   modport master (
      output in_fetcher_flag, in_fetcher_pc, in_mem_flag, in_mem_inst,
      input  out_fetcher_flag, out_fetcher_inst, out_mem_flag, out_mem_pc
   );
endinterface

// File: rtl/icache.sv
// icache: direct-mapped single-word-line instruction cache with miss refill and xbp abort
//   clk, rst (sync, active-high), rdy (low freezes everything)
//   bus        : icache_if.slave, fetcher request/response and memory read request/response
//   in_rob_xbp : misprediction flush, aborts any outstanding miss
//   out_hit_cnt, out_miss_cnt : lookup statistics, present only when ICACHE_STATS_EN is defined
module icache #(
   parameter int INDEX_BITS = 8,
   parameter int ADDR_BITS  = 18
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   icache_if.slave     bus,
   input  logic        in_rob_xbp
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0] out_hit_cnt,
   output logic [31:0] out_miss_cnt
`endif
);
   localparam int LINES = 1 << INDEX_BITS;
   localparam int TAG_W = ADDR_BITS - INDEX_BITS - 2;
   typedef enum logic [1:0] {IDLE, MISS, RESP} state_t;
   state_t                state, state_n;
   logic [LINES-1:0]      valid;
   logic [TAG_W-1:0]      tags [LINES];
   logic [31:0]           data [LINES];
   logic                  fflag, fflag_n, mflag, mflag_n, wr, hit;
   logic [31:0]           finst, finst_n, mpc, mpc_n;
   logic [INDEX_BITS-1:0] idx, widx;
   logic [TAG_W-1:0]      tag, wtag;
   logic                  unused_pc_lsb;
   assign idx  = bus.in_fetcher_pc[INDEX_BITS+1:2];
   assign tag  = bus.in_fetcher_pc[ADDR_BITS-1:INDEX_BITS+2];
   // the refill target comes from the held miss address, not the live fetcher PC
   assign widx = mpc[INDEX_BITS+1:2];
   assign wtag = mpc[ADDR_BITS-1:INDEX_BITS+2];
   assign hit  = valid[idx] && tags[idx] == tag;
   assign unused_pc_lsb = ^bus.in_fetcher_pc[1:0];
   assign bus.out_fetcher_flag = fflag;
   assign bus.out_fetcher_inst = finst;
   assign bus.out_mem_flag     = mflag;
   assign bus.out_mem_pc       = mpc;
   always_comb begin
      state_n = state;
      fflag_n = 1'b0;
      finst_n = finst;
      mflag_n = mflag;
      mpc_n   = mpc;
      wr      = 1'b0;
      if (in_rob_xbp) begin
         state_n = IDLE;
         mflag_n = 1'b0;
      end else begin
         case (state)
            IDLE: if (bus.in_fetcher_flag) begin
               if (hit) begin
                  finst_n = data[idx];
                  fflag_n = 1'b1;
                  state_n = RESP;
               end else begin
                  mflag_n = 1'b1;
                  mpc_n   = {bus.in_fetcher_pc[31:2], 2'b00};
                  state_n = MISS;
               end
            end
            MISS: if (bus.in_mem_flag) begin
               wr      = 1'b1;
               mflag_n = 1'b0;
               finst_n = bus.in_mem_inst;
               fflag_n = 1'b1;
               state_n = RESP;
            end
            RESP: state_n = IDLE;
            default: state_n = IDLE;
         endcase
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         fflag <= 1'b0;
         finst <= '0;
         mflag <= 1'b0;
         mpc   <= '0;
         valid <= '0;
      end else if (rdy) begin
         state <= state_n;
         fflag <= fflag_n;
         finst <= finst_n;
         mflag <= mflag_n;
         mpc   <= mpc_n;
         if (wr) valid[widx] <= 1'b1;
      end
   end
   always_ff @(posedge clk) begin
      if (!rst && rdy && wr) begin
         tags[widx] <= wtag;
         data[widx] <= bus.in_mem_inst;
      end
   end
`ifdef ICACHE_STATS_EN
   logic lookup;
   assign lookup = state == IDLE && bus.in_fetcher_flag && !in_rob_xbp;
   always_ff @(posedge clk) begin
      if (rst) begin
         out_hit_cnt  <= '0;
         out_miss_cnt <= '0;
      end else if (rdy && lookup) begin
         if (hit) out_hit_cnt <= out_hit_cnt + 32'd1;
         else out_miss_cnt <= out_miss_cnt + 32'd1;
      end
   end
`endif
endmodule
